// File: rtl/mem_responder.sv
// Memory-side responder: word array read with fixed latency, in-order response FIFO,
// outstanding-request credit counter and an independent backdoor write port.
module mem_responder #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WORDS      = 1024,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned RESP_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_data_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_data_o,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  idle_o
);

    localparam int unsigned IW   = $clog2(WORDS);
    localparam int unsigned OFS  = $clog2(DATA_WIDTH / 8);
    localparam int unsigned CW   = $clog2(RESP_DEPTH + 1);
    localparam int unsigned PW   = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int unsigned NSTG = (LATENCY > 1) ? LATENCY - 1 : 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(RESP_DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(RESP_DEPTH - 1);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    logic                  req_fire;
    logic                  resp_fire;
    logic [IW-1:0]         rd_idx;
    logic [IW-1:0]         wr_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  push_vld;
    logic [DATA_WIDTH-1:0] push_dat;
    logic                  unused_addr_bits;

    logic [DATA_WIDTH-1:0] mem_q [WORDS];

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         fcnt_q, fcnt_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [DATA_WIDTH-1:0] fifo_q [RESP_DEPTH];

    assign req_ready_o  = (cnt_q < DEPTH_C);
    assign idle_o       = (cnt_q == '0);
    assign resp_valid_o = (fcnt_q != '0);
    assign resp_data_o  = fifo_q[rd_ptr_q];

    assign req_fire  = req_valid_i & req_ready_o;
    assign resp_fire = resp_valid_o & resp_ready_i;

    // Offset bits and bits above the word index alias onto the same word.
    assign rd_idx           = req_data_i[OFS +: IW];
    assign wr_idx           = wr_addr_i[OFS +: IW];
    assign unused_addr_bits = ^{req_data_i, wr_addr_i};

    // Combinational read sees the pre-write word when a backdoor write hits the same index.
    assign rd_word = mem_q[rd_idx];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_idx] <= wr_data_i;
        end
    end

    generate
        if (LATENCY > 1) begin : g_pipe
            logic                  pipe_vld_q [NSTG];
            logic [DATA_WIDTH-1:0] pipe_dat_q [NSTG];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int unsigned i = 0; i < NSTG; i++) begin
                        pipe_vld_q[i] <= 1'b0;
                    end
                end else begin
                    pipe_vld_q[0] <= req_fire;
                    for (int unsigned i = 1; i < NSTG; i++) begin
                        pipe_vld_q[i] <= pipe_vld_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                pipe_dat_q[0] <= rd_word;
                for (int unsigned i = 1; i < NSTG; i++) begin
                    pipe_dat_q[i] <= pipe_dat_q[i-1];
                end
            end

            assign push_vld = pipe_vld_q[NSTG-1];
            assign push_dat = pipe_dat_q[NSTG-1];
        end else begin : g_nopipe
            assign push_vld = req_fire;
            assign push_dat = rd_word;
        end
    endgenerate

    always_comb begin
        cnt_d = cnt_q;
        unique case ({req_fire, resp_fire})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // cnt covers pipeline plus FIFO, so a push never finds the FIFO full without a pop.
    always_comb begin
        fcnt_d   = fcnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push_vld) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (resp_fire) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({push_vld, resp_fire})
            2'b10:   fcnt_d = fcnt_q + 1'b1;
            2'b01:   fcnt_d = fcnt_q - 1'b1;
            default: fcnt_d = fcnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            fcnt_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            fcnt_q   <= fcnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_vld) begin
            fifo_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed stimulus pushes expected words,
// a negedge monitor pops and compares every response handshake.
module tb_mem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        idle;

    int          vectors;
    int          miscompares;
    logic [31:0] exp_q [$];

    mem_responder #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .WORDS      (1024),
        .LATENCY    (2),
        .RESP_DEPTH (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_data_i   (req_data),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_data_o  (resp_data),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .idle_o       (idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change at posedge+1, so at negedge a valid&&ready pair is a handshake.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL resp_unexpected: got %08h, required no response", resp_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (resp_data !== e) begin
                    miscompares++;
                    $display("FAIL resp_data: got %08h, required %08h", resp_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic bd_write(input logic [31:0] addr, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic send(input logic [31:0] addr, input logic [31:0] exp);
        int unsigned n;
        n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        check("send_ready", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_data  = addr;
        exp_q.push_back(exp);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while ((exp_q.size() != 0 || !idle) && n < 50) begin
            tick();
            n++;
        end
        check("drain_pending", exp_q.size(), 32'd0);
        check("drain_idle", {31'b0, idle}, 32'd1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_data    = '0;
        resp_ready  = 1'b1;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_idle", {31'b0, idle}, 32'd1);

        // Single read: response exactly two cycles after acceptance.
        bd_write(32'h14, 32'hDEADBEEF);
        req_valid = 1'b1;
        req_data  = 32'h14;
        exp_q.push_back(32'hDEADBEEF);
        check("t1_valid_T", {31'b0, resp_valid}, 32'd0);
        tick();
        req_valid = 1'b0;
        check("t1_valid_T1", {31'b0, resp_valid}, 32'd0);
        check("t1_idle_T1", {31'b0, idle}, 32'd0);
        tick();
        check("t1_valid_T2", {31'b0, resp_valid}, 32'd1);
        check("t1_data_T2", resp_data, 32'hDEADBEEF);
        tick();
        check("t1_valid_T3", {31'b0, resp_valid}, 32'd0);
        check("t1_idle_T3", {31'b0, idle}, 32'd1);

        // Streaming: 8 back-to-back requests, one response per cycle.
        for (int i = 0; i < 8; i++) bd_write(32'(i * 4), 32'hC0DE0000 + 32'(i));
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1;
            req_data  = 32'(i * 4);
            check("t2_req_ready", {31'b0, req_ready}, 32'd1);
            check("t2_resp_valid", {31'b0, resp_valid}, (i >= 2) ? 32'd1 : 32'd0);
            exp_q.push_back(32'hC0DE0000 + 32'(i));
            tick();
        end
        req_valid = 1'b0;
        check("t2_tail0", {31'b0, resp_valid}, 32'd1);
        tick();
        check("t2_tail1", {31'b0, resp_valid}, 32'd1);
        tick();
        check("t2_tail_end", {31'b0, resp_valid}, 32'd0);
        drain();

        // Backpressure: only RESP_DEPTH requests accepted, head held stable.
        resp_ready = 1'b0;
        begin
            int k;
            k = 0;
            for (int c = 0; c < 8; c++) begin
                req_valid = 1'b1;
                req_data  = 32'(k * 4);
                check("t3_req_ready", {31'b0, req_ready}, (c < 4) ? 32'd1 : 32'd0);
                if (c >= 2) begin
                    check("t3_hold_valid", {31'b0, resp_valid}, 32'd1);
                    check("t3_hold_data", resp_data, 32'hC0DE0000);
                end
                if (req_ready) begin
                    exp_q.push_back(32'hC0DE0000 + 32'(k));
                    k++;
                end
                tick();
            end
            check("t3_accepted", 32'(k), 32'd4);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        check("t3_ready_X", {31'b0, req_ready}, 32'd0);
        tick();
        check("t3_ready_X1", {31'b0, req_ready}, 32'd1);
        tick();
        tick();
        check("t3_valid_X3", {31'b0, resp_valid}, 32'd1);
        tick();
        check("t3_valid_X4", {31'b0, resp_valid}, 32'd0);
        drain();

        // Same-cycle write and read to one word returns the old value.
        bd_write(32'h0C, 32'h11);
        wr_en     = 1'b1;
        wr_addr   = 32'h0C;
        wr_data   = 32'h22;
        req_valid = 1'b1;
        req_data  = 32'h0C;
        exp_q.push_back(32'h11);
        tick();
        wr_en     = 1'b0;
        req_valid = 1'b0;
        send(32'h0C, 32'h22);
        drain();

        // Aliasing: upper and offset address bits ignored.
        send(32'h1014, 32'hC0DE0005);
        send(32'h17, 32'hC0DE0005);
        drain();

        // Mid-operation reset drops queued and in-flight responses.
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_data  = 32'(i * 4);
            tick();
        end
        req_valid = 1'b0;
        check("t5_busy", {31'b0, idle}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("t5_idle", {31'b0, idle}, 32'd1);
        check("t5_req_ready", {31'b0, req_ready}, 32'd1);
        resp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("t5_quiet", {31'b0, resp_valid}, 32'd0);
            tick();
        end

        // Normal operation resumes after reset.
        send(32'h1C, 32'hC0DE0007);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
